// File: rtl/cache_req_arbiter.sv
// Two-port request arbiter in front of a single cache controller: latches the winner's request and holds it until done.
// Optional build macro ARB_FIXED_PRIO_EN: port 0 always wins simultaneous requests; otherwise round-robin.
module cache_req_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_type,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    input  logic              req1_type,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              done_cache,
    input  logic [DATA_W-1:0] cache_rdata,
    output logic              ctrl_req_valid,
    output logic              ctrl_req_type,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic [DATA_W-1:0] ctrl_wdata,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              type_q, type_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              any_req;
    logic              pick1;
    logic              accept;

    assign any_req = req0_valid | req1_valid;
    assign accept  = (state_q == ST_IDLE) & any_req;

`ifdef ARB_FIXED_PRIO_EN
    assign pick1 = ~req0_valid;
`else
    logic last_gnt_q;

    // Port 1 wins when alone, or when both request and port 0 won last time.
    assign pick1 = req1_valid & (~req0_valid | ~last_gnt_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
        end else if (accept) begin
            last_gnt_q <= pick1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        type_d  = type_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_BUSY;
                    gnt0_d  = ~pick1;
                    gnt1_d  = pick1;
                    type_d  = pick1 ? req1_type  : req0_type;
                    addr_d  = pick1 ? req1_addr  : req0_addr;
                    wdata_d = pick1 ? req1_wdata : req0_wdata;
                end
            end
            ST_BUSY: begin
                if (done_cache) begin
                    state_d = ST_IDLE;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            type_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign ctrl_req_valid = (state_q == ST_BUSY);
    assign busy           = (state_q == ST_BUSY);
    assign ctrl_req_type  = type_q;
    assign ctrl_addr      = addr_q;
    assign ctrl_wdata     = wdata_q;
    assign gnt0           = gnt0_q;
    assign gnt1           = gnt1_q;
    // Completion pulses follow the controller's done combinationally.
    assign done0          = (state_q == ST_BUSY) & gnt0_q & done_cache;
    assign done1          = (state_q == ST_BUSY) & gnt1_q & done_cache;
    assign rsp_rdata      = cache_rdata;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Self-checking bench for cache_req_arbiter: transaction-level model compared every cycle plus directed scenarios.
module tb_cache_req_arbiter;

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_type = 1'b0, req1_type = 1'b0;
    logic [31:0] req0_addr = '0, req1_addr = '0;
    logic [31:0] req0_wdata = '0, req1_wdata = '0;
    logic        done_cache = 1'b0;
    logic [31:0] cache_rdata = '0;
    logic        ctrl_req_valid, ctrl_req_type, gnt0, gnt1, done0, done1, busy;
    logic [31:0] ctrl_addr, ctrl_wdata, rsp_rdata;

    int checks = 0;
    int errors = 0;

    cache_req_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_type(req0_type), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_type(req1_type), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .done_cache(done_cache), .cache_rdata(cache_rdata),
        .ctrl_req_valid(ctrl_req_valid), .ctrl_req_type(ctrl_req_type),
        .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rsp_rdata(rsp_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: owner is -1 when idle, else the port currently served.
    int          owner = -1;
    int          last_winner = 1;
    logic        m_type = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;

    always @(posedge clk) begin
        int w;
        if (rst) begin
            owner = -1; last_winner = 1; m_type = 1'b0; m_addr = '0; m_wdata = '0;
        end else if (owner < 0) begin
            w = -1;
            if (req0_valid && req1_valid) w = FIXED ? 0 : 1 - last_winner;
            else if (req0_valid)          w = 0;
            else if (req1_valid)          w = 1;
            if (w >= 0) begin
                owner = w;
                last_winner = w;
                m_type  = (w == 1) ? req1_type  : req0_type;
                m_addr  = (w == 1) ? req1_addr  : req0_addr;
                m_wdata = (w == 1) ? req1_wdata : req0_wdata;
            end
        end else if (done_cache) begin
            owner = -1;
        end
    end

    bit   started = 1'b0;
    logic busy_prev = 1'b0;
    int   order[$];
    int   d0_cnt = 0, d1_cnt = 0;

    // Per-cycle comparison against the model, plus grant-order and done-pulse bookkeeping.
    always @(negedge clk) begin
        if (started) begin
            check("busy", busy, owner >= 0);
            check("ctrl_req_valid", ctrl_req_valid, owner >= 0);
            check("gnt0", gnt0, owner == 0);
            check("gnt1", gnt1, owner == 1);
            check("gnt_onehot", gnt0 & gnt1, 1'b0);
            check("done0", done0, (owner == 0) && done_cache);
            check("done1", done1, (owner == 1) && done_cache);
            check("rsp_rdata", rsp_rdata, cache_rdata);
            if (owner >= 0) begin
                check("ctrl_req_type", ctrl_req_type, m_type);
                check("ctrl_addr", ctrl_addr, m_addr);
                check("ctrl_wdata", ctrl_wdata, m_wdata);
            end
            if (done0) d0_cnt++;
            if (done1) d1_cnt++;
            if (busy && !busy_prev) order.push_back(gnt1 ? 1 : 0);
            busy_prev = busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0; req1_valid = 1'b0; done_cache = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        order.delete();
    endtask

    // Wait for a grant, let it run ncyc cycles, then complete it; optionally keep the requester asserted.
    task automatic serve(input int ncyc, input bit hold);
        int  t;
        logic g1;
        t = 0;
        while (!busy && t < 20) begin
            tick();
            t++;
        end
        if (!busy) begin
            checks++;
            errors++;
            $display("FAIL serve_timeout: busy got 0 expected 1 at %0t", $time);
            return;
        end
        repeat (ncyc) tick();
        done_cache = 1'b1;
        g1 = gnt1;
        tick();
        done_cache = 1'b0;
        if (!hold) begin
            if (g1) req1_valid = 1'b0;
            else    req0_valid = 1'b0;
        end
    endtask

    task automatic check_order(input string name, input int exp_q[$]);
        check({name, "_len"}, 64'(order.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < order.size(); i++)
            check(name, 64'(order[i]), 64'(exp_q[i]));
    endtask

    initial begin
        int p0, p1;
        int exp36[$];

        tick();
        started = 1'b1;
        do_reset();

        // Reset values
        check("rst_ctrl_req_valid", ctrl_req_valid, 1'b0);
        check("rst_ctrl_req_type", ctrl_req_type, 1'b0);
        check("rst_ctrl_addr", ctrl_addr, 32'h0);
        check("rst_ctrl_wdata", ctrl_wdata, 32'h0);
        check("rst_gnt", {gnt1, gnt0}, 2'b00);
        check("rst_done", {done1, done0}, 2'b00);
        check("rst_busy", busy, 1'b0);

        // Single read from port 0
        req0_valid = 1'b1; req0_type = 1'b0; req0_addr = 32'h100;
        tick();
        check("rd0_gnt0", gnt0, 1'b1);
        check("rd0_valid", ctrl_req_valid, 1'b1);
        check("rd0_type", ctrl_req_type, 1'b0);
        check("rd0_addr", ctrl_addr, 32'h100);
        tick(); tick();
        p0 = d0_cnt;
        done_cache = 1'b1; cache_rdata = 32'hCAFE0001;
        #1;
        check("rd0_done0", done0, 1'b1);
        check("rd0_rsp_rdata", rsp_rdata, 32'hCAFE0001);
        tick();
        done_cache = 1'b0; req0_valid = 1'b0;
        check("rd0_idle", busy, 1'b0);
        tick();
        check("rd0_done_pulses", 64'(d0_cnt - p0), 64'd1);

        // done_cache in IDLE is ignored
        p0 = d0_cnt; p1 = d1_cnt;
        done_cache = 1'b1;
        #1;
        check("idle_done_pulse", {done1, done0}, 2'b00);
        tick();
        done_cache = 1'b0;
        check("idle_done_state", busy, 1'b0);
        tick();
        check("idle_done_cnt", 64'(d0_cnt + d1_cnt - p0 - p1), 64'd0);

        // Simultaneous reads right after reset
        do_reset();
        req0_valid = 1'b1; req0_type = 1'b0; req0_addr = 32'h10;
        req1_valid = 1'b1; req1_type = 1'b0; req1_addr = 32'h20;
        serve(1, 1'b0);
        check("sim_gap_idle", busy, 1'b0);
        serve(1, 1'b0);
        tick();
        check_order("sim_order", '{0, 1});

        // Continuous contention for four transactions
        do_reset();
        req0_valid = 1'b1; req0_addr = 32'hA0;
        req1_valid = 1'b1; req1_addr = 32'hB0;
        for (int i = 0; i < 4; i++) serve(1, 1'b1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); tick();
        if (FIXED) exp36 = '{0, 0, 0, 0};
        else       exp36 = '{0, 1, 0, 1};
        check_order("rr_order", exp36);

        // Latched write survives requester changes
        do_reset();
        req1_valid = 1'b1; req1_type = 1'b1; req1_addr = 32'h2000; req1_wdata = 32'hDEADBEEF;
        tick();
        req1_addr = 32'h3000; req1_wdata = 32'h12345678; req1_type = 1'b0;
        tick(); tick();
        check("wr1_gnt1", gnt1, 1'b1);
        check("wr1_type", ctrl_req_type, 1'b1);
        check("wr1_addr", ctrl_addr, 32'h2000);
        check("wr1_wdata", ctrl_wdata, 32'hDEADBEEF);
        done_cache = 1'b1;
        #1;
        check("wr1_done1", {done1, done0}, 2'b10);
        check("wr1_addr_at_done", ctrl_addr, 32'h2000);
        tick();
        done_cache = 1'b0; req1_valid = 1'b0;
        tick();

        // Reset during BUSY aborts without a done pulse
        req0_valid = 1'b1; req0_type = 1'b1; req0_addr = 32'h40; req0_wdata = 32'h55AA55AA;
        tick();
        check("abort_busy", busy, 1'b1);
        p0 = d0_cnt; p1 = d1_cnt;
        rst = 1'b1;
        tick();
        check("abort_outputs",
              {ctrl_req_valid, ctrl_req_type, gnt0, gnt1, done0, done1, busy}, 7'b0);
        check("abort_addr", ctrl_addr, 32'h0);
        check("abort_wdata", ctrl_wdata, 32'h0);
        rst = 1'b0;
        req1_valid = 1'b1; req1_type = 1'b0; req1_addr = 32'h80;
        tick();
        check("abort_no_done", 64'(d0_cnt + d1_cnt - p0 - p1), 64'd0);
        check("abort_next_gnt", {gnt1, gnt0}, 2'b01);
        serve(0, 1'b0);
        serve(0, 1'b0);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_req_arbiter.md
CACHE_REQ_ARBITER -- requirements
Module: cache_req_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, request address width.
REQ-002 Parameter: DATA_W, default 32, write/read data width.
REQ-003 The block SHALL be clocked by clk, with one clock domain; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Ports: req0_valid/req1_valid  input  1  requester N has a pending request; held high until doneN.
REQ-007 Ports: req0_type/req1_type  input  1  0 = read, 1 = write.
REQ-008 Ports: req0_addr/req1_addr  input  ADDR_W  request address.
REQ-009 Ports: req0_wdata/req1_wdata  input  DATA_W  write data.
REQ-010 Port: done_cache  input  1  cache_controller transaction-complete pulse.
REQ-011 Port: cache_rdata  input  DATA_W  read data from cache datapath.
REQ-012 Ports: ctrl_req_valid / ctrl_req_type  output  1 / 1  request to cache_controller.
REQ-013 Ports: ctrl_addr / ctrl_wdata  output  ADDR_W / DATA_W  latched address and write data of granted request.
REQ-014 Ports: gnt0/gnt1  output  1  one-hot owner of the cache; both 0 when idle.
REQ-015 Ports: done0/done1  output  1  one-cycle completion pulse to requester N.
REQ-016 Port: rsp_rdata  output  DATA_W  combinational copy of cache_rdata, valid when doneN=1 for a read.
REQ-017 Port: busy  output  1  high while in BUSY.

Function
REQ-018 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-019 In IDLE with any reqN_valid=1 at a rising edge, the winner's type, addr and wdata SHALL be latched, gntN set, state -> BUSY.
REQ-020 In IDLE with no valid request, state SHALL remain IDLE and all grant outputs SHALL remain 0.
REQ-021 In BUSY, ctrl_req_valid SHALL be 1 and ctrl_req_type/ctrl_addr/ctrl_wdata SHALL be the latched values, unaffected by requester input changes.
REQ-022 Latency: ctrl_req_valid SHALL rise exactly one cycle after the accepting edge.
REQ-023 doneN SHALL equal (state==BUSY) & gntN & done_cache, combinationally.
REQ-024 On the rising edge with done_cache=1 in BUSY, the FSM SHALL enter IDLE, clear gnt0/gnt1 and ctrl_req_valid; at least one IDLE cycle separates transactions.
REQ-025 done_cache in IDLE SHALL be ignored.
REQ-026 Round-robin: a last_gnt register SHALL record the most recent winner; when both request in IDLE, the port other than last_gnt SHALL win.
REQ-027 When only one port requests, that port SHALL win regardless of last_gnt.
REQ-028 Requests arriving during BUSY SHALL NOT alter the grant and SHALL be arbitrated on return to IDLE.
REQ-029 gnt0 and gnt1 SHALL never be 1 simultaneously.

Reset
REQ-030 On rst=1 at a rising edge, state SHALL be IDLE, last_gnt SHALL be 1 (port 0 preferred first), and the latched request registers SHALL be 0.
REQ-031 Output values after reset SHALL be: ctrl_req_valid=0, ctrl_req_type=0, ctrl_addr=0, ctrl_wdata=0, gnt0=gnt1=0, done0=done1=0, busy=0.
REQ-032 Reset asserted during BUSY SHALL abort the transaction with no doneN pulse.

Configuration
REQ-033 Macro ARB_FIXED_PRIO_EN: when defined, port 0 SHALL always win a simultaneous request and last_gnt is not used; when undefined, the round-robin rules in REQ-026 apply.

Verification
REQ-034 Reset, then req0 read addr 0x100 -> gnt0=1 and ctrl_req_valid=1 with type=0 and addr=0x100 next cycle; done_cache raised 3 cycles later -> done0 pulses once and FSM returns to IDLE.
REQ-035 Both ports request a read in the same cycle immediately after reset -> port 0 is served first, then port 1 after one IDLE cycle.
REQ-036 Both ports request continuously for 4 transactions -> grant order 0,1,0,1 (without ARB_FIXED_PRIO_EN) and 0,0,0,0 (with the macro defined).
REQ-037 req1 write with addr 0x2000 and wdata 0xDEADBEEF, then req1_addr changed to 0x3000 during BUSY -> ctrl_addr stays 0x2000 and ctrl_wdata stays 0xDEADBEEF until done1.
REQ-038 rst pulsed during BUSY -> all outputs equal 0 the next cycle, no doneN pulse, and the next simultaneous request is won by port 0.
REQ-039 done_cache pulsed while in IDLE -> no doneN pulse and no state change.
